// File: rtl/sprite_attr_writer_pkg.sv
// Shared types and constants for the sprite attribute writer.
// Attribute word: [9:0] x, [18:10] y, [23:19] sprite id.
package sprite_pkg;

  localparam int NUM_SPRITES = 20;
  localparam int ATTR_W      = 24;
  localparam int V_ACTIVE    = 480;

  localparam logic [4:0] ADDR_CTRL   = 5'd20;
  localparam logic [4:0] ADDR_STATUS = 5'd21;

  typedef struct packed {
    logic [4:0] id;
    logic [8:0] y;
    logic [9:0] x;
  } sprite_attr_t;

  // Parks a sprite off the visible area: x=1023, y=511, id=0.
  localparam sprite_attr_t ATTR_OFFSCREEN = '{
    id: 5'd0,
    y:  9'h1FF,
    x:  10'h3FF
  };

endpackage

// File: rtl/sprite_attr_writer_vblank_edge_det.sv
// Vertical-blank start detector.
// Ports: clk, reset (async high), vcount in; vblank_start pulse out.
module vblank_edge_det
  import sprite_pkg::*;
#(
  parameter int VSTART = V_ACTIVE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vcount,
  output logic       vblank_start
);

  logic in_vblank;
  logic vblank_d;
  logic vblank_q;

  assign in_vblank = (vcount >= 10'(VSTART));

  always_comb begin
    vblank_d = in_vblank;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank_d;
    end
  end

  // Edge rather than level, so a line count that holds for many
  // clocks still yields one pulse per frame.
  assign vblank_start = in_vblank & ~vblank_q & ~reset;

endmodule

// File: rtl/sprite_attr_writer.sv
// Avalon-MM slave holding shadow/active sprite attribute banks.
// Ports: clk, reset, Avalon (chipselect/write/read/address/writedata/
// readdata), VGA_VCOUNT in; sprite_attr, frame_irq, commit_pending out.
// Build option: SPRITE_ATTR_READBACK_EN enables shadow-entry reads.
module sprite_attr_writer
  import sprite_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic                          read,
  input  logic [4:0]                    address,
  input  logic [31:0]                   writedata,
  output logic [31:0]                   readdata,
  input  logic [9:0]                    VGA_VCOUNT,
  output logic [NUM_SPRITES*ATTR_W-1:0] sprite_attr,
  output logic                          frame_irq,
  output logic                          commit_pending
);

  sprite_attr_t shadow_q [NUM_SPRITES];
  sprite_attr_t shadow_d [NUM_SPRITES];
  sprite_attr_t active_q [NUM_SPRITES];
  sprite_attr_t active_d [NUM_SPRITES];

  logic        commit_pending_q;
  logic        commit_pending_d;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  frame_cnt_d;
  logic [31:0] readdata_q;
  logic [31:0] readdata_d;

  logic vblank_start;
  logic wr_en;
  logic rd_en;
  logic entry_sel;
  logic unused_wdata;

  vblank_edge_det #(
    .VSTART(V_ACTIVE)
  ) u_vblank (
    .clk          (clk),
    .reset        (reset),
    .vcount       (VGA_VCOUNT),
    .vblank_start (vblank_start)
  );

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign entry_sel    = (address < 5'(NUM_SPRITES));
  assign unused_wdata = ^writedata[31:24];

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && entry_sel) begin
      shadow_d[address] = sprite_attr_t'(writedata[ATTR_W-1:0]);
    end
  end

  // The copy reads shadow_q, so a same-cycle shadow write lands only
  // in shadow; a same-cycle CTRL write re-arms for the next frame.
  always_comb begin
    active_d         = active_q;
    commit_pending_d = commit_pending_q;
    frame_cnt_d      = frame_cnt_q;
    if (vblank_start) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (commit_pending_q) begin
        active_d         = shadow_q;
        commit_pending_d = 1'b0;
      end
    end
    if (wr_en && (address == ADDR_CTRL) && writedata[0]) begin
      commit_pending_d = 1'b1;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      unique case (1'b1)
        (address == ADDR_CTRL): begin
          readdata_d = {31'b0, commit_pending_q};
        end
        (address == ADDR_STATUS): begin
          readdata_d = {16'b0, frame_cnt_q, 7'b0, commit_pending_q};
        end
`ifdef SPRITE_ATTR_READBACK_EN
        entry_sel: begin
          readdata_d = {8'b0, shadow_q[address]};
        end
`endif
        default: begin
          readdata_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= ATTR_OFFSCREEN;
        active_q[i] <= ATTR_OFFSCREEN;
      end
      commit_pending_q <= 1'b0;
      frame_cnt_q      <= 8'd0;
      readdata_q       <= 32'd0;
    end else begin
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      commit_pending_q <= commit_pending_d;
      frame_cnt_q      <= frame_cnt_d;
      readdata_q       <= readdata_d;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
    assign sprite_attr[g*ATTR_W +: ATTR_W] = active_q[g];
  end

  assign readdata       = readdata_q;
  assign frame_irq      = vblank_start;
  assign commit_pending = commit_pending_q;

endmodule

// File: tb/tb_sprite_attr_writer.sv
// Scoreboard bench for sprite_attr_writer.
// Directed frame scenarios followed by randomized bus and line traffic.
module tb_sprite_attr_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         chipselect;
  logic         write;
  logic         read;
  logic [4:0]   address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [9:0]   VGA_VCOUNT;
  logic [479:0] sprite_attr;
  logic         frame_irq;
  logic         commit_pending;

  always #5 clk = ~clk;

  sprite_attr_writer dut (
    .clk            (clk),
    .reset          (reset),
    .chipselect     (chipselect),
    .write          (write),
    .read           (read),
    .address        (address),
    .writedata      (writedata),
    .readdata       (readdata),
    .VGA_VCOUNT     (VGA_VCOUNT),
    .sprite_attr    (sprite_attr),
    .frame_irq      (frame_irq),
    .commit_pending (commit_pending)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [23:0] ent(input int i);
    return sprite_attr[i*24 +: 24];
  endfunction

  // Reference model: the two banks, the pending flag, the frame count.
  logic [23:0] m_sh  [20];
  logic [23:0] m_act [20];
  bit          m_pend;
  logic [7:0]  m_fc;
  bit          m_prev;
  logic [31:0] exp_q [$];
  bit          rd_due;

  task automatic model_reset();
    for (int i = 0; i < 20; i++) begin
      m_sh[i]  = 24'h07FFFF;
      m_act[i] = 24'h07FFFF;
    end
    m_pend = 0;
    m_fc   = 8'd0;
    m_prev = 0;
    exp_q.delete();
    rd_due = 0;
  endtask

  function automatic logic [31:0] read_model(input logic [4:0] a);
    if (a < 5'd20) begin
`ifdef SPRITE_ATTR_READBACK_EN
      return {8'h00, m_sh[a]};
`else
      return 32'd0;
`endif
    end
    if (a == 5'd20) return {31'b0, m_pend};
    if (a == 5'd21) return {16'b0, m_fc, 7'b0, m_pend};
    return 32'd0;
  endfunction

  task automatic model_clock();
    bit vb;
    bit st;
    vb     = (VGA_VCOUNT >= 10'd480);
    st     = vb && !m_prev;
    m_prev = vb;
    rd_due = 0;
    if (chipselect && read) begin
      exp_q.push_back(read_model(address));
      rd_due = 1;
    end
    if (st) begin
      m_fc = m_fc + 8'd1;
      if (m_pend) begin
        for (int i = 0; i < 20; i++) m_act[i] = m_sh[i];
        m_pend = 0;
      end
    end
    if (chipselect && write) begin
      if (address < 5'd20) m_sh[address] = writedata[23:0];
      else if (address == 5'd20 && writedata[0]) m_pend = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_clock();
    end
  end

  // Monitor: compares outputs mid-cycle against the model.
  initial begin
    logic [479:0] exp_flat;
    bit           exp_irq;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 20; i++) exp_flat[i*24 +: 24] = m_act[i];
      total++;
      if (sprite_attr !== exp_flat) begin
        bad++;
        $display("FAIL sprite_attr got=%h exp=%h", sprite_attr, exp_flat);
      end
      chk("commit_pending", {31'b0, commit_pending}, {31'b0, m_pend});
      exp_irq = !reset && (VGA_VCOUNT >= 10'd480) && !m_prev;
      chk("frame_irq", {31'b0, frame_irq}, {31'b0, exp_irq});
      if (rd_due) begin
        rd_due = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL readdata got=%h exp=<none queued>", readdata);
        end else begin
          chk("readdata", readdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit w, input bit r, input logic [4:0] a,
                      input logic [31:0] d);
    @(posedge clk);
    #1;
    chipselect = w | r;
    write      = w;
    read       = r;
    address    = a;
    writedata  = d;
  endtask

  task automatic setv(input logic [9:0] v);
    step(0, 0, 5'd0, 32'd0);
    VGA_VCOUNT = v;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [9:0] v;
    logic [31:0] rd_exp;
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = 5'd0;
    writedata  = 32'd0;
    VGA_VCOUNT = 10'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Build some state, then reset asynchronously mid-cycle.
    step(1, 0, 5'd2, 32'h0000_0123);
    step(1, 0, 5'd20, 32'd1);
    setv(10'd479);
    setv(10'd480);
    step(1, 0, 5'd7, 32'h00AB_CDEF);
    step(1, 0, 5'd20, 32'd1);
    step(0, 1, 5'd21, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 20; i++)
      chk("rst_entry", {8'h0, ent(i)}, 32'h0007_FFFF);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_pending", {31'b0, commit_pending}, 32'd0);
    chk("rst_irq", {31'b0, frame_irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    VGA_VCOUNT = 10'd0;

    // No commit: a full frame sweep must not touch the active bank.
    step(1, 0, 5'd3, 32'h00A4_0850);
    cnt = 0;
    for (int k = 0; k <= 524; k++) begin
      setv(10'(k));
      @(negedge clk);
      if (frame_irq) cnt++;
    end
    chk("hold_irq_count", 32'(cnt), 32'd1);
    chk("hold_entry3", {8'h0, ent(3)}, 32'h0007_FFFF);
    step(0, 1, 5'd21, 32'd0);
    idle();
    chk("hold_status", readdata, 32'h0000_0100);

    // Commit applied at vblank start, one irq for a held line count.
    setv(10'd0);
    step(1, 0, 5'd20, 32'd1);
    setv(10'd479);
    chk("commit_armed", {31'b0, commit_pending}, 32'd1);
    setv(10'd480);
    @(negedge clk);
    cnt = frame_irq ? 1 : 0;
    setv(10'd480);
    chk("commit_entry3", {8'h0, ent(3)}, 32'h00A4_0850);
    chk("commit_cleared", {31'b0, commit_pending}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) setv(10'd480);
      @(negedge clk);
      if (frame_irq) cnt++;
    end
    chk("held_irq_count", 32'(cnt), 32'd1);

    // CTRL write on the vblank-start cycle waits a frame.
    setv(10'd0);
    step(1, 0, 5'd5, 32'h0012_3456);
    setv(10'd479);
    step(1, 0, 5'd20, 32'd1);
    VGA_VCOUNT = 10'd480;
    idle();
    chk("coinc_pending", {31'b0, commit_pending}, 32'd1);
    chk("coinc_entry5", {8'h0, ent(5)}, 32'h0007_FFFF);
    setv(10'd0);
    setv(10'd480);
    idle();
    chk("coinc_entry5_next", {8'h0, ent(5)}, 32'h0012_3456);
    chk("coinc_cleared", {31'b0, commit_pending}, 32'd0);

    // Shadow write on the copy cycle: active gets the old shadow.
    setv(10'd0);
    step(1, 0, 5'd0, 32'h0000_0001);
    step(1, 0, 5'd20, 32'd1);
    setv(10'd479);
    step(1, 0, 5'd0, 32'hFF00_0002);
    VGA_VCOUNT = 10'd480;
    idle();
    chk("copy_old_entry0", {8'h0, ent(0)}, 32'h0000_0001);
    step(1, 0, 5'd20, 32'd1);
    setv(10'd0);
    setv(10'd480);
    idle();
    chk("copy_new_entry0", {8'h0, ent(0)}, 32'h0000_0002);

    // Register reads.
    step(1, 0, 5'd3, 32'h00A4_0850);
    step(0, 1, 5'd3, 32'd0);
    idle();
`ifdef SPRITE_ATTR_READBACK_EN
    rd_exp = 32'h00A4_0850;
`else
    rd_exp = 32'd0;
`endif
    chk("read_entry3", readdata, rd_exp);
    step(0, 1, 5'd25, 32'd0);
    idle();
    chk("read_addr25", readdata, 32'd0);
    step(1, 0, 5'd20, 32'd1);
    step(1, 0, 5'd20, 32'd1);
    step(0, 1, 5'd20, 32'd0);
    idle();
    chk("read_ctrl", readdata, 32'd1);
    idle();
    chk("read_hold", readdata, 32'd1);

    // Frame counter wrap from a clean reset.
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    VGA_VCOUNT = 10'd0;
    for (int k = 0; k < 255; k++) begin
      setv(10'd479);
      setv(10'd480);
    end
    step(0, 1, 5'd21, 32'd0);
    idle();
    chk("status_255", readdata, 32'h0000_FF00);
    setv(10'd479);
    setv(10'd480);
    step(0, 1, 5'd21, 32'd0);
    chk("status_latency", readdata, 32'h0000_FF00);
    idle();
    chk("status_wrap", readdata, 32'd0);

    // Random traffic with a wandering line counter.
    v = 10'd470;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [4:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a = 5'($urandom_range(0, 21));
      d = $urandom;
      if (r <= 3) step(1, 0, a, d);
      else if (r <= 6) step(0, 1, a, d);
      else idle();
      if ($urandom_range(0, 15) == 0) chipselect = 1'b0;
      if ($urandom_range(0, 9) < 7) v = (v >= 10'd524) ? 10'd0 : v + 10'd1;
      else if ($urandom_range(0, 1) == 1) v = 10'($urandom_range(476, 484));
      else v = 10'($urandom_range(0, 524));
      VGA_VCOUNT = v;
      if (n == 1500) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
    end
    repeat (3) idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_attr_writer.md
Name: sprite_attr_writer

Overview:
- Avalon-MM slave through which the HPS/CPU writes per-sprite attribute words.
- Drives the 20 attribute buses (sprite1..sprite20) consumed by the sprite compositor.
- Holds a CPU-writable shadow bank and a display-facing active bank. The shadow bank is copied into the active bank only at the start of vertical blank, and only after a commit request, so sprites never tear mid-frame.
- Sits between the Avalon fabric and the sprite controller in the VGA top level.

Parameters:
NUM_SPRITES, 20, number of attribute entries
V_ACTIVE, 480, first VGA_VCOUNT value that is vertical blank
ATTR_W, 24, attribute word width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  5  word address
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
VGA_VCOUNT  in  10  current VGA line from timing generator
sprite_attr  out  NUM_SPRITES*ATTR_W  active bank, flat; entry i at [24*i+23:24*i]; top level splits it to sprite1..sprite20
frame_irq  out  1  one-cycle pulse at each vblank start
commit_pending  out  1  commit requested, not yet applied

Behaviour:
- Reset: one clock, clk; asynchronous active-high reset.
  - All shadow and active entries reset to ATTR_OFFSCREEN (x=1023, y=511, id=0), i.e. 24'h07FFFF.
  - readdata=0, frame_irq=0, commit_pending=0, frame_cnt=0, vblank_q=0.
- Attribute format: [9:0] x, [18:10] y (9 bits), [23:19] sprite id.
- Address map:
  - 0..NUM_SPRITES-1: shadow entry. A write stores writedata[23:0]; bits [31:24] are ignored.
  - 20 CTRL: a write with writedata[0]=1 sets commit_pending; other bits are ignored. Reads return {31'b0, commit_pending}.
  - 21 STATUS (read-only): {16'b0, frame_cnt[7:0], 7'b0, commit_pending}. Writes are ignored.
  - 22..31: writes ignored, reads return 0.
- Reads: one-cycle latency. readdata is valid on the cycle after chipselect&read and holds until the next read. There is no waitrequest.
- Vblank detection:
  - in_vblank = (VGA_VCOUNT >= V_ACTIVE); vblank_q is its registered copy.
  - vblank_start = in_vblank & ~vblank_q.
  - This is immune to VGA_VCOUNT holding across many clk cycles.
- On vblank_start:
  - frame_irq=1 for that single cycle.
  - frame_cnt increments, wrapping 255->0.
  - If commit_pending=1: all active entries load shadow in one cycle, and commit_pending clears.
- Simultaneous events:
  - CTRL commit write coincident with vblank_start: the write does not join this copy. commit_pending ends at 1 and applies at the next vblank.
  - Shadow write coincident with a copy: active receives the pre-write shadow value; shadow holds the new value.
  - CTRL commit while already pending: no effect, remains pending.
- Reset mid-frame: all state returns to reset values immediately. Any pending commit is discarded.
- sprite_attr changes only on a vblank_start cycle or on reset.

Optional Feature:
- Macro SPRITE_ATTR_READBACK_EN.
- Defined: reads of addresses 0..NUM_SPRITES-1 return {8'b0, shadow[i]}.
- Undefined: those reads return 0, and no read mux over the shadow bank is built.
- CTRL and STATUS reads are present in both builds.

Decomposition:
- Package sprite_pkg holds: ATTR_W, NUM_SPRITES, ATTR_OFFSCREEN, the address constants (ADDR_CTRL=20, ADDR_STATUS=21), and typedef sprite_attr_t (packed struct: id[4:0], y[8:0], x[9:0]).
- One sub-module, vblank_edge_det: registers in_vblank and emits the vblank_start pulse. Everything else stays in sprite_attr_writer.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> all sprite_attr entries 24'h07FFFF, readdata=0, commit_pending=0, frame_irq=0.
- No-commit hold: write entry 3 = 0x00A4_0850, no commit, sweep VGA_VCOUNT 0->524 -> entry 3 of sprite_attr stays 24'h07FFFF; frame_irq pulses once at VCOUNT 480; STATUS frame_cnt=1.
- Commit applied: write entry 3 = 0x00A4_0850, write CTRL=1, then VCOUNT 479->480 -> entry 3 = 24'hA40850 on the vblank_start cycle; commit_pending 1->0; VCOUNT held at 480 for 10 cycles gives only one frame_irq.
- Commit coincident with vblank_start: commit lands on the vblank_start cycle -> no copy that frame, commit_pending=1 afterwards; the next vblank applies it.
- Shadow write coincident with copy: shadow[0]=0x000001 pending, write shadow[0]=0x000002 on the vblank_start cycle -> active[0]=0x000001; after a second commit+vblank, active[0]=0x000002.
- Reads and wrap: read STATUS after 256 vblanks -> frame_cnt=0, with readdata arriving one cycle after read. With SPRITE_ATTR_READBACK_EN, reading address 3 returns 0x00A4_0850; without it, returns 0; address 25 returns 0.
